// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the piso_tx serializer
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int PISO_WIDTH_DEF = 4;

    // Bit counter width; a 1-bit floor keeps the counter declarable for tiny words.
    function automatic int piso_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// rtl/jk_ff_sync.sv - JK flip-flop with synchronous active-low reset to 0
module jk_ff_sync (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, MSB first, valid/ready load
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = piso_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    piso_state_e      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_bar;
    logic [WIDTH-1:0] sr_next;
    logic             in_shift;
    logic             last_bit;
    logic             accept;

    assign in_shift   = (state == SHIFT);
    assign last_bit   = in_shift && (cnt == '0);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // Load takes precedence; otherwise shift toward the MSB with zero fill.
    always_comb begin
        sr_next = sr;
        if (accept) begin
            sr_next = din;
        end else if (in_shift) begin
            sr_next = {sr[WIDTH-2:0], 1'b0};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_ff_sync u_stage (
            .clk   (clk),
            .rst   (rst),
            .j     (sr_next[i]),
            .k     (~sr_next[i]),
            .q     (sr[i]),
            .q_bar (sr_bar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= CNT_LAST;
        end else if (in_shift) begin
            if (cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign serial_out   = in_shift && sr[WIDTH-1];
    assign serial_valid = in_shift;
    assign busy         = in_shift;
    assign done         = last_bit;

    // Zero fill means a fully shifted word leaves the register clear before IDLE.
    a_idle_clear: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE) |-> (&sr_bar));

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx with SIPO loopback
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       serial_out;
    logic       serial_valid;
    logic       busy;
    logic       done;

    logic       sipo_rst;
    logic [3:0] sipo_out;

    int errors = 0;
    int checks = 0;

    piso_tx #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sipo_rst = ~rst;
    always_ff @(posedge clk) begin
        if (sipo_rst) sipo_out <= 4'h0;
        else          sipo_out <= {sipo_out[2:0], serial_out};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; load_valid = 1'b1; din = 4'hF;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({load_ready, serial_valid, serial_out, busy, done} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got rdy/sv/so/busy/done=%b want 10000", c,
                         {load_ready, serial_valid, serial_out, busy, done});
            end
        end
        rst = 1'b1; load_valid = 1'b0;
        step();
        checks++;
        if ({busy, serial_valid, load_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_no_accept: got busy/sv/rdy=%b want 001", {busy, serial_valid, load_ready});
        end
    endtask

    task automatic test_single();
        logic [3:0] w;
        w = 4'hB;
        din = w; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({serial_out, serial_valid, busy, done, load_ready} !== {w[3-i], 1'b1, 1'b1, (i == 3), (i == 3)}) begin
                errors++;
                $display("FAIL single_bit%0d: got so/sv/busy/done/rdy=%b want %b", i,
                         {serial_out, serial_valid, busy, done, load_ready},
                         {w[3-i], 1'b1, 1'b1, (i == 3), (i == 3)});
            end
            step();
        end
        checks++;
        if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL single_idle: got so/sv/busy/done/rdy=%b want 00001",
                     {serial_out, serial_valid, busy, done, load_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'hA5;
        din = 4'hA; load_valid = 1'b1;
        step();
        din = 4'h5;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({serial_out, serial_valid, done} !== {pat[7-i], 1'b1, (i == 3 || i == 7)}) begin
                errors++;
                $display("FAIL b2b_bit%0d: got so/sv/done=%b want %b", i,
                         {serial_out, serial_valid, done}, {pat[7-i], 1'b1, (i == 3 || i == 7)});
            end
            if (i == 7) load_valid = 1'b0;
            step();
        end
        checks++;
        if ({serial_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: got sv/busy=%b want 00", {serial_valid, busy});
        end
    endtask

    task automatic test_loopback();
        for (int v = 0; v < 16; v++) begin
            int k;
            din = 4'(v); load_valid = 1'b1;
            step();
            load_valid = 1'b0;
            k = 0;
            while (!done && k < 8) begin
                step();
                k++;
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL loopback_timeout value %0d: done=%b want 1", v, done);
            end
            step();
            checks++;
            if (sipo_out !== 4'(v)) begin
                errors++;
                $display("FAIL loopback_word: got %h want %h", sipo_out, 4'(v));
            end
        end
    endtask

    task automatic test_ignored_load();
        logic [7:0] pat;
        pat = 8'hC3;
        din = 4'hC; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                load_valid = 1'b1; din = 4'h3;
            end
            checks++;
            if ({serial_out, serial_valid, load_ready, done} !==
                {pat[7-i], 1'b1, (i == 3 || i == 7), (i == 3 || i == 7)}) begin
                errors++;
                $display("FAIL ignored_bit%0d: got so/sv/rdy/done=%b want %b", i,
                         {serial_out, serial_valid, load_ready, done},
                         {pat[7-i], 1'b1, (i == 3 || i == 7), (i == 3 || i == 7)});
            end
            step();
            if (i == 3) load_valid = 1'b0;
        end
        checks++;
        if ({serial_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ignored_idle: got sv/busy=%b want 00", {serial_valid, busy});
        end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] w;
        din = 4'hF; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if ({serial_out, serial_valid} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_bit2: got so/sv=%b want 11", {serial_out, serial_valid});
        end
        step();
        rst = 1'b1;
        checks++;
        if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL midreset_idle: got so/sv/busy/done/rdy=%b want 00001",
                     {serial_out, serial_valid, busy, done, load_ready});
        end
        w = 4'h9;
        din = w; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({serial_out, serial_valid, done} !== {w[3-i], 1'b1, (i == 3)}) begin
                errors++;
                $display("FAIL midreset_reload_bit%0d: got so/sv/done=%b want %b", i,
                         {serial_out, serial_valid, done}, {w[3-i], 1'b1, (i == 3)});
            end
            step();
        end
        checks++;
        if ({serial_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_final_idle: got sv/busy=%b want 00", {serial_valid, busy});
        end
    endtask

    initial begin
        rst = 1'b0; load_valid = 1'b0; din = 4'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_loopback();
        test_ignored_load();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
